ps2_key_decoder: RTL and testbench

Converts the raw PS/2 scan-code byte stream into held-key bitmaps for both players. It sits between the PS/2 frame receiver (bit-level deserialiser) and VGA_Draw, whose per-player Up/Left/Right/Down/Fire inputs it drives. It handles make, break, extended and Pause sequences, and keyboard self-test and overrun codes. It is a pure byte-level state machine with a prefix timeout.

---
 rtl/ps2_key_decoder.sv | 177 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code bytes to per-player held-key bitmaps; optional debug latch via KEY_DEBUG_EN
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_In,
  input  logic [7:0] Byte_In,
  input  logic       Byte_Valid_In,
  input  logic       Frame_Err_In,
  output logic [4:0] P1_Keys_Out,
  output logic [4:0] P2_Keys_Out,
  output logic       Key_Event_Out,
  output logic [7:0] Debug_Out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(PAUSE_SKIP + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_INIT = SW'(PAUSE_SKIP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timeout_cnt;
  logic [SW-1:0] skip_cnt;
  logic [9:0]    keys;       // {P2[4:0], P1[4:0]}
  logic [9:0]    keys_next;
  logic          key_event;
  logic          accepted;

  // A byte flagged with a frame error is never consumed.
  assign accepted = Byte_Valid_In && !Frame_Err_In;

  // Bit position of a scan code in the combined {P2, P1} bitmap; zero when unmapped.
  function automatic logic [9:0] key_mask(input logic [7:0] code, input logic ext);
    logic [9:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h1D:   m[0] = 1'b1;
        8'h1C:   m[1] = 1'b1;
        8'h23:   m[2] = 1'b1;
        8'h1B:   m[3] = 1'b1;
        8'h29:   m[4] = 1'b1;
        8'h5A:   m[9] = 1'b1;
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h75:   m[5] = 1'b1;
        8'h6B:   m[6] = 1'b1;
        8'h74:   m[7] = 1'b1;
        8'h72:   m[8] = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // State register; reset discards any half-received sequence.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state: prefix tracking, frame-error abort and idle timeout.
  always_comb begin
    state_next = state;
    if (Frame_Err_In) begin
      state_next = ST_IDLE;
    end else if (Byte_Valid_In) begin
      case (state)
        ST_IDLE: begin
          case (Byte_In)
            8'hE0:   state_next = ST_EXT;
            8'hF0:   state_next = ST_BRK;
            8'hE1:   state_next = ST_SKIP;
            default: state_next = ST_IDLE;
          endcase
        end
        ST_EXT:     state_next = (Byte_In == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_next = ST_IDLE;
        ST_EXT_BRK: state_next = ST_IDLE;
        ST_SKIP:    state_next = (skip_cnt <= SW'(1)) ? ST_IDLE : ST_SKIP;
        default:    state_next = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && timeout_cnt == T_LAST) begin
      state_next = ST_IDLE;
    end
  end

  // Output decode: the byte that completes a sequence sets, clears or wipes bitmap bits.
  always_comb begin
    keys_next = keys;
    if (accepted) begin
      case (state)
        ST_IDLE: begin
          case (Byte_In)
            8'hAA, 8'h00, 8'hFF:                keys_next = '0;
            8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hFE:  keys_next = keys;
            default:                            keys_next = keys | key_mask(Byte_In, 1'b0);
          endcase
        end
        ST_EXT: begin
          if (Byte_In != 8'hE0 && Byte_In != 8'hF0)
            keys_next = keys | key_mask(Byte_In, 1'b1);
        end
        ST_BRK: begin
          if (Byte_In != 8'hF0)
            keys_next = keys & ~key_mask(Byte_In, 1'b0);
        end
        ST_EXT_BRK: keys_next = keys & ~key_mask(Byte_In, 1'b1);
        default:    keys_next = keys;
      endcase
    end
  end

  // Idle counter: runs only while a sequence is pending, restarts on each byte, saturates.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In || Byte_Valid_In || state == ST_IDLE)
      timeout_cnt <= '0;
    else if (timeout_cnt != T_LAST)
      timeout_cnt <= timeout_cnt + TW'(1);
  end

  // Pause skip counter: loaded on E1, counts down one per accepted byte while skipping.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      skip_cnt <= '0;
    end else if (state_next == ST_SKIP) begin
      if (state != ST_SKIP)
        skip_cnt <= S_INIT;
      else if (accepted)
        skip_cnt <= skip_cnt - SW'(1);
    end else begin
      skip_cnt <= '0;
    end
  end

  // Bitmap register and change pulse, aligned with the new bitmap value.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      keys      <= '0;
      key_event <= 1'b0;
    end else begin
      keys      <= keys_next;
      key_event <= (keys_next != keys);
    end
  end

  assign P1_Keys_Out   = keys[4:0];
  assign P2_Keys_Out   = keys[9:5];
  assign Key_Event_Out = key_event;

`ifdef KEY_DEBUG_EN
  logic [7:0] debug_q;

  // Debug latch holds the most recent accepted byte.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In)      debug_q <= 8'h00;
    else if (accepted) debug_q <= Byte_In;
  end

  assign Debug_Out = debug_q;
`else
  assign Debug_Out = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized self-checking bench for ps2_key_decoder against a sequence-level model
module tb_ps2_key_decoder;

  localparam int TO = 20;
  localparam int PS = 7;

  localparam logic [7:0] P1_CODES [5] = '{8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h29};
  localparam logic [7:0] P2_EXT   [4] = '{8'h75, 8'h6B, 8'h74, 8'h72};
  localparam logic [7:0] KEYS_ALL [10] = '{8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h29,
                                           8'h75, 8'h6B, 8'h74, 8'h72, 8'h5A};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       valid = 1'b0;
  logic       ferr = 1'b0;
  logic [4:0] p1;
  logic [4:0] p2;
  logic       evt;
  logic [7:0] dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: pending prefix bytes, remaining Pause bytes, idle clocks since last byte
  logic [4:0] m_p1 = '0;
  logic [4:0] m_p2 = '0;
  logic       m_evt = 1'b0;
  logic [7:0] m_dbg = 8'h00;
  logic [7:0] pend[$];
  int         skip_left = 0;
  int         idle = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .PAUSE_SKIP(PS)) dut (
    .Master_Clock_In (clk),
    .Reset_In        (rst),
    .Byte_In         (byte_in),
    .Byte_Valid_In   (valid),
    .Frame_Err_In    (ferr),
    .P1_Keys_Out     (p1),
    .P2_Keys_Out     (p2),
    .Key_Event_Out   (evt),
    .Debug_Out       (dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {P2, P1} bits addressed by a code, from the key tables
  function automatic logic [9:0] lookup(input logic [7:0] b, input logic ext);
    logic [9:0] m = '0;
    if (!ext) begin
      for (int i = 0; i < 5; i++) if (b == P1_CODES[i]) m[i] = 1'b1;
      if (b == 8'h5A) m[9] = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (b == P2_EXT[i]) m[5+i] = 1'b1;
    end
    return m;
  endfunction

  task automatic model(input logic r, input logic v, input logic e, input logic [7:0] b);
    logic [4:0] n1 = m_p1;
    logic [4:0] n2 = m_p2;
    logic [9:0] mk;
    logic is_ext, is_brk;
    if (r) begin
      n1 = '0; n2 = '0; pend.delete(); skip_left = 0; idle = 0; m_dbg = 8'h00;
    end else if (e) begin
      pend.delete(); skip_left = 0; idle = 0;
    end else if (v) begin
      idle = 0;
`ifdef KEY_DEBUG_EN
      m_dbg = b;
`endif
      if (skip_left > 0) begin
        skip_left--;
      end else if (pend.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
        else if (b == 8'hE1) skip_left = PS;
        else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin n1 = '0; n2 = '0; end
        else if (b != 8'hFA && b != 8'hFE) begin
          mk = lookup(b, 1'b0); n1 |= mk[4:0]; n2 |= mk[9:5];
        end
      end else begin
        is_ext = (pend[0] == 8'hE0);
        is_brk = (pend[pend.size()-1] == 8'hF0);
        if (pend.size() == 1 && is_ext && b == 8'hF0) pend.push_back(b);
        else if (pend.size() == 1 && b == pend[0]) pend.delete();
        else begin
          mk = lookup(b, is_ext);
          if (is_brk) begin n1 &= ~mk[4:0]; n2 &= ~mk[9:5]; end
          else        begin n1 |= mk[4:0];  n2 |= mk[9:5];  end
          pend.delete();
        end
      end
    end else if (pend.size() != 0 || skip_left > 0) begin
      idle++;
      if (idle >= TO) begin pend.delete(); skip_left = 0; idle = 0; end
    end
    m_evt = r ? 1'b0 : ({n2, n1} != {m_p2, m_p1});
    m_p1 = n1;
    m_p2 = n2;
  endtask

  // one clock: drive on the falling edge, compare just after the rising edge
  task automatic step(input logic r, input logic v, input logic e, input logic [7:0] b);
    @(negedge clk);
    rst = r; valid = v; ferr = e; byte_in = b;
    @(posedge clk);
    #1;
    model(r, v, e, b);
    check("p1", p1, m_p1);
    check("p2", p2, m_p2);
    check("evt", evt, m_evt);
    check("dbg", dbg, m_dbg);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, 1'b0, b);
  endtask

  task automatic idle_clk(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 99);
    if (r < 40) return KEYS_ALL[$urandom_range(0, 9)];
    if (r < 58) return 8'hE0;
    if (r < 74) return 8'hF0;
    if (r < 77) return 8'hE1;
    if (r < 78) return ($urandom_range(0, 2) == 0) ? 8'hAA : (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
    if (r < 81) return ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hFE;
    return 8'($urandom);
  endfunction

  initial begin
    int r;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_p1", p1, 5'd0);
    check("rst_p2", p2, 5'd0);
    check("rst_evt", evt, 1'b0);
    idle_clk(2);

    // make then break of W
    send(8'h1D);
    check("tp1_make", p1, 5'b00001);
    check("tp1_evt1", evt, 1'b1);
    send(8'hF0); send(8'h1D);
    check("tp1_break", p1, 5'b00000);
    check("tp1_evt2", evt, 1'b1);

    // P2 extended Up, Enter, extended break of Up
    send(8'hE0); send(8'h75);
    check("tp2_up", p2, 5'b00001);
    send(8'h5A);
    check("tp2_fire", p2, 5'b10001);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("tp2_rel", p2, 5'b10000);
    check("tp2_p1", p1, 5'b00000);
    send(8'hF0); send(8'h5A);

    // Pause sequence swallowed, then Space
    foreach (P1_CODES[i]) begin end
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("tp3_p1", p1, 5'b00000);
    check("tp3_p2", p2, 5'b00000);
    send(8'h29);
    check("tp3_fire", p1, 5'b10000);

    // clear with everything held, then clear with nothing held
    send(8'h1D); send(8'h1C); send(8'h23); send(8'h1B); send(8'hF0); send(8'h29);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74); send(8'hE0); send(8'h72); send(8'h5A);
    check("tp4_p1_held", p1, 5'b01111);
    check("tp4_p2_held", p2, 5'b11111);
    send(8'hAA);
    check("tp4_clr_p1", p1, 5'd0);
    check("tp4_clr_p2", p2, 5'd0);
    check("tp4_clr_evt", evt, 1'b1);
    send(8'h00);
    check("tp4_noevt", evt, 1'b0);

    // prefix timeout boundary
    send(8'hE0); idle_clk(TO); send(8'h75);
    check("tp5_timeout", p2[0], 1'b0);
    send(8'hE0); idle_clk(TO - 1); send(8'h75);
    check("tp5_edge", p2[0], 1'b1);
    send(8'hE0); idle_clk(1); send(8'hF0); send(8'h75);
    check("tp5_short", p2[0], 1'b0);

    // frame error wins over a valid byte
    send(8'h1D);
    send(8'hF0);
    step(1'b0, 1'b1, 1'b1, 8'h1D);
    check("tp6_held", p1[0], 1'b1);
    send(8'h1C);
    check("tp6_left", p1, 5'b00011);

    // reset mid-sequence drops the pending prefix
    send(8'hE0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h75);
    check("rst_mid", p2[0], 1'b0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 999);
      if (r < 3)        step(1'b1, 1'($urandom), 1'b0, pick());
      else if (r < 25)  step(1'b0, 1'($urandom), 1'b1, pick());
      else if (r < 60)  idle_clk($urandom_range(TO - 2, TO + 2));
      else if (r < 300) idle_clk($urandom_range(1, 3));
      else              send(pick());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
